// File: rtl/jam_pkg.sv
// ---------------------------------------------------------------------------
// jam_pkg
// Shared definitions for the exhaustive job-assignment solver (jam_param) and
// its next-permutation engine (jam_nextperm).
//   - default sizing values for the number of workers, cost width, sum width
//     and match-count width
//   - the controller state encoding and the permutation engine phase encoding
//   - CLOG2, an index-width helper that never returns less than one bit
// ---------------------------------------------------------------------------
package jam_pkg;

  localparam int DEF_N   = 8;
  localparam int DEF_CW  = 7;
  localparam int DEF_SW  = 10;
  localparam int DEF_MCW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_JUDGE,
    ST_PIVOT,
    ST_SWAP,
    ST_REVERSE,
    ST_DONE
  } jam_state_e;

  typedef enum logic [1:0] {
    NP_IDLE,
    NP_SWAP,
    NP_REV
  } np_phase_e;

  // Ceiling log2. A one-bit minimum is returned so that an index port always
  // has a legal width, even for a degenerate single-entry range.
  function automatic int CLOG2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/jam_nextperm.sv
// ---------------------------------------------------------------------------
// jam_nextperm
// Owns the permutation register array and steps it to its lexicographic
// successor on request.
//
// Ports
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset, loads the identity permutation
//   init_i   synchronous reload of the identity permutation
//   start_i  request one successor step (only honoured when idle)
//   done_o   high during the final cycle of a step; the array holds the
//            successor from the following edge on
//   last_o   the current permutation is fully descending (no successor)
//   perm_o   flattened array, entry i at bits [i*IW +: IW]
//
// A step takes three cycles: the pivot/successor indices are captured, the
// two entries are swapped, then the suffix after the pivot is reversed.
// ---------------------------------------------------------------------------
module jam_nextperm
  import jam_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = CLOG2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            init_i,
  input  logic            start_i,
  output logic            done_o,
  output logic            last_o,
  output logic [N*IW-1:0] perm_o
);

  np_phase_e     phase_q, phase_d;
  logic [IW-1:0] perm_q [N];
  logic [IW-1:0] perm_d [N];
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] l_q, l_d;
  logic [IW-1:0] pivotIdx;
  logic [IW-1:0] succIdx;
  logic          pivotFound;

  // Pivot search: the rightmost position whose entry is smaller than its
  // right-hand neighbour. The ascending scan lets later hits overwrite
  // earlier ones. No hit at all means the array is fully descending, which is
  // the last permutation in lexicographic order.
  always_comb begin
    pivotFound = 1'b0;
    pivotIdx   = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) begin
        pivotFound = 1'b1;
        pivotIdx   = IW'(i);
      end
    end
  end

  // Successor search: the rightmost entry beyond the pivot that is larger
  // than the pivot entry. Because the suffix is descending this is also the
  // smallest such larger entry, which is what keeps the order lexicographic.
  always_comb begin
    succIdx = '0;
    for (int i = 0; i < N; i++) begin
      if ((IW'(i) > pivotIdx) && (perm_q[i] > perm_q[pivotIdx])) begin
        succIdx = IW'(i);
      end
    end
  end

  // Step sequencer. The indices are frozen in k/l at request time so that the
  // swap and the reversal both refer to the same pivot even though the array
  // changes underneath the combinational search between phases. The reversal
  // mirrors positions k+1..N-1 in a single cycle.
  always_comb begin
    phase_d = phase_q;
    k_d     = k_q;
    l_d     = l_q;
    for (int i = 0; i < N; i++) begin
      perm_d[i] = perm_q[i];
    end
    if (init_i) begin
      phase_d = NP_IDLE;
      for (int i = 0; i < N; i++) begin
        perm_d[i] = IW'(i);
      end
    end else begin
      case (phase_q)
        NP_IDLE: begin
          if (start_i) begin
            k_d     = pivotIdx;
            l_d     = succIdx;
            phase_d = NP_SWAP;
          end
        end
        NP_SWAP: begin
          perm_d[k_q] = perm_q[l_q];
          perm_d[l_q] = perm_q[k_q];
          phase_d     = NP_REV;
        end
        NP_REV: begin
          for (int i = 0; i < N; i++) begin
            if (i > int'(k_q)) begin
              perm_d[i] = perm_q[IW'(N + int'(k_q) - i)];
            end
          end
          phase_d = NP_IDLE;
        end
        default: begin
          phase_d = NP_IDLE;
        end
      endcase
    end
  end

  // State register; reset leaves the identity permutation in place so the
  // first run can start summing straight away.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= NP_IDLE;
      k_q     <= '0;
      l_q     <= '0;
      for (int i = 0; i < N; i++) begin
        perm_q[i] <= IW'(i);
      end
    end else begin
      phase_q <= phase_d;
      k_q     <= k_d;
      l_q     <= l_d;
      for (int i = 0; i < N; i++) begin
        perm_q[i] <= perm_d[i];
      end
    end
  end

  // Flatten the array for the parent and expose the handshake flags.
  always_comb begin
    perm_o = '0;
    for (int i = 0; i < N; i++) begin
      perm_o[i*IW +: IW] = perm_q[i];
    end
    done_o = (phase_q == NP_REV);
    last_o = !pivotFound;
  end

endmodule

// File: rtl/jam_param.sv
// ---------------------------------------------------------------------------
// jam_param
// Exhaustive solver for the N x N assignment problem. Every permutation of
// jobs over workers is visited in lexicographic order; for each one the cost
// table is read one (worker, job) pair per cycle and the total compared with
// the best seen so far. The result is the best total, how many permutations
// reach it, and the first (lexicographically smallest) optimal assignment.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   Start      one-cycle run request, honoured only when not Busy
//   Mode       0 = minimise, 1 = maximise; captured with Start
//   W, J       registered worker/job index presented to the external table
//   Cost       table entry for (W, J), sampled at the end of the cycle
//   Busy       run in progress
//   MinCost    best total found (minimum or maximum depending on Mode)
//   MatchCount number of permutations reaching MinCost, saturating
//   BestJob    job of worker i at bits [i*IW +: IW] for the first optimum
//   Valid      results final; held until the next accepted Start or RST
// ---------------------------------------------------------------------------
module jam_param
  import jam_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IW    = CLOG2(N),
  parameter int CW    = DEF_CW,
  parameter int SW    = DEF_SW,
  parameter int MCW   = DEF_MCW,
  parameter int PRUNE = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            Mode,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic            Busy,
  output logic [SW-1:0]   MinCost,
  output logic [MCW-1:0]  MatchCount,
  output logic [N*IW-1:0] BestJob,
  output logic            Valid
);

  jam_state_e      state_q, state_d;
  logic [IW-1:0]   w_q, w_d;
  logic [IW-1:0]   j_q, j_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic            mode_q, mode_d;
  logic            have_q, have_d;
  logic [SW-1:0]   minCost_q, minCost_d;
  logic [MCW-1:0]  matchCount_q, matchCount_d;
  logic [N*IW-1:0] bestJob_q, bestJob_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;

  logic            npInit;
  logic            npStart;
  logic            npDone;
  logic            npLast;
  logic [N*IW-1:0] permFlat;
  logic [IW-1:0]   permAt [N];

  logic [SW-1:0]   sumNext;
  logic [IW-1:0]   wNext;
  logic            pruneHit;
  logic            better;
  logic            tie;

  jam_nextperm #(
    .N  (N),
    .IW (IW)
  ) u_nextperm (
    .clk_i   (CLK),
    .rst_i   (RST),
    .init_i  (npInit),
    .start_i (npStart),
    .done_o  (npDone),
    .last_o  (npLast),
    .perm_o  (permFlat)
  );

  // Unpack the permutation so the job for the next worker can be selected by
  // index when the next table address is registered.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      permAt[i] = permFlat[i*IW +: IW];
    end
  end

  // Controller next-state logic.
  // SUM registers the next table address each cycle while the current Cost is
  // folded into the partial sum. In minimise mode a permutation is abandoned
  // as soon as its partial sum is strictly above the recorded best; ties keep
  // going so they are still counted. The last permutation is never abandoned
  // so that the run always finishes through JUDGE, which is where Valid is
  // raised. On leaving REVERSE the first job is read straight from the array:
  // position 0 is only ever touched by the swap, never by the reversal, so it
  // already holds its final value during the REVERSE cycle.
  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    j_d          = j_q;
    sum_d        = sum_q;
    mode_d       = mode_q;
    have_d       = have_q;
    minCost_d    = minCost_q;
    matchCount_d = matchCount_q;
    bestJob_d    = bestJob_q;
    busy_d       = busy_q;
    valid_d      = valid_q;
    npInit       = 1'b0;
    npStart      = 1'b0;
    sumNext      = sum_q + SW'(Cost);
    wNext        = w_q + IW'(1);
    pruneHit     = (PRUNE != 0) && !mode_q && have_q && !npLast && (sumNext > minCost_q);
    better       = mode_q ? (sum_q > minCost_q) : (sum_q < minCost_q);
    tie          = (sum_q == minCost_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d = ST_SUM;
          npInit  = 1'b1;
          mode_d  = Mode;
          have_d  = 1'b0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          w_d     = '0;
          j_d     = '0;
          sum_d   = '0;
        end
      end
      ST_SUM: begin
        sum_d = sumNext;
        if (pruneHit) begin
          state_d = ST_PIVOT;
        end else if (w_q == IW'(N - 1)) begin
          state_d = ST_JUDGE;
        end else begin
          w_d = wNext;
          j_d = permAt[wNext];
        end
      end
      ST_JUDGE: begin
        if (!have_q || better) begin
          minCost_d    = sum_q;
          matchCount_d = MCW'(1);
          bestJob_d    = permFlat;
          have_d       = 1'b1;
        end else if (tie && (matchCount_q != '1)) begin
          matchCount_d = matchCount_q + MCW'(1);
        end
        if (npLast) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          state_d = ST_PIVOT;
        end
      end
      ST_PIVOT: begin
        npStart = 1'b1;
        state_d = ST_SWAP;
      end
      ST_SWAP: begin
        state_d = ST_REVERSE;
      end
      ST_REVERSE: begin
        if (npDone) begin
          state_d = ST_SUM;
          w_d     = '0;
          j_d     = permAt[0];
          sum_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller and result registers. Reset returns everything to the idle
  // values and nothing moves again until the next Start is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      w_q          <= '0;
      j_q          <= '0;
      sum_q        <= '0;
      mode_q       <= 1'b0;
      have_q       <= 1'b0;
      minCost_q    <= '0;
      matchCount_q <= '0;
      bestJob_q    <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      j_q          <= j_d;
      sum_q        <= sum_d;
      mode_q       <= mode_d;
      have_q       <= have_d;
      minCost_q    <= minCost_d;
      matchCount_q <= matchCount_d;
      bestJob_q    <= bestJob_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  assign W          = w_q;
  assign J          = j_q;
  assign Busy       = busy_q;
  assign MinCost    = minCost_q;
  assign MatchCount = matchCount_q;
  assign BestJob    = bestJob_q;
  assign Valid      = valid_q;

endmodule

// File: tb/tb_jam_param.sv
`timescale 1ns/1ps
module tb_jam_param;

  localparam int NA  = 4;
  localparam int IWA = 2;
  localparam int NC  = 3;
  localparam int IWC = 2;
  localparam int ND  = 6;
  localparam int IWD = 3;
  localparam int CWT = 7;
  localparam int SWT = 10;
  localparam int MCT = 16;

  typedef struct {
    longint minCost;
    longint matchCount;
    longint bestJob;
  } exp_t;

  // Clock and shared controls
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;
  logic startAB;
  logic modeAB;
  logic startCD;

  // DUT A (pruning) and DUT B (no pruning) share the random cost table
  logic [CWT-1:0] costTab [NA][NA];

  logic [IWA-1:0]    wA, jA, wB, jB;
  logic [CWT-1:0]    costA, costB;
  logic              busyA, busyB, validA, validB;
  logic [SWT-1:0]    minCostA, minCostB;
  logic [MCT-1:0]    matchCountA, matchCountB;
  logic [NA*IWA-1:0] bestJobA, bestJobB;

  logic [IWC-1:0]    wC, jC;
  logic [CWT-1:0]    costC;
  logic              busyC, validC;
  logic [SWT-1:0]    minCostC;
  logic [MCT-1:0]    matchCountC;
  logic [NC*IWC-1:0] bestJobC;

  logic [IWD-1:0]    wD, jD;
  logic [CWT-1:0]    costD;
  logic              busyD, validD;
  logic [SWT-1:0]    minCostD;
  logic [MCT-1:0]    matchCountD;
  logic [ND*IWD-1:0] bestJobD;

  assign costA = costTab[wA][jA];
  assign costB = costTab[wB][jB];
  assign costC = CWT'(wC) * CWT'(jC);
  assign costD = CWT'(5);

  jam_param #(.N(NA), .IW(IWA), .CW(CWT), .SW(SWT), .MCW(MCT), .PRUNE(1)) dutA (
    .CLK(CLK), .RST(RST), .Start(startAB), .Mode(modeAB), .W(wA), .J(jA), .Cost(costA),
    .Busy(busyA), .MinCost(minCostA), .MatchCount(matchCountA), .BestJob(bestJobA), .Valid(validA)
  );

  jam_param #(.N(NA), .IW(IWA), .CW(CWT), .SW(SWT), .MCW(MCT), .PRUNE(0)) dutB (
    .CLK(CLK), .RST(RST), .Start(startAB), .Mode(modeAB), .W(wB), .J(jB), .Cost(costB),
    .Busy(busyB), .MinCost(minCostB), .MatchCount(matchCountB), .BestJob(bestJobB), .Valid(validB)
  );

  jam_param #(.N(NC), .IW(IWC), .CW(CWT), .SW(SWT), .MCW(MCT), .PRUNE(1)) dutC (
    .CLK(CLK), .RST(RST), .Start(startCD), .Mode(1'b0), .W(wC), .J(jC), .Cost(costC),
    .Busy(busyC), .MinCost(minCostC), .MatchCount(matchCountC), .BestJob(bestJobC), .Valid(validC)
  );

  jam_param #(.N(ND), .IW(IWD), .CW(CWT), .SW(SWT), .MCW(MCT), .PRUNE(1)) dutD (
    .CLK(CLK), .RST(RST), .Start(startCD), .Mode(1'b0), .W(wD), .J(jD), .Cost(costD),
    .Busy(busyD), .MinCost(minCostD), .MatchCount(matchCountD), .BestJob(bestJobD), .Valid(validD)
  );

  // Scoreboard queues and counters
  exp_t qA[$];
  exp_t qB[$];
  exp_t qC[$];
  exp_t qD[$];
  int checks = 0;
  int passes = 0;

  // Single comparison point: every check steps the counters here
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic compareResult(input string tag, input exp_t e, input longint mc,
                               input longint cnt, input longint bj, input logic busy);
    checkOutput({tag, " MinCost"}, mc, e.minCost);
    checkOutput({tag, " MatchCount"}, cnt, e.matchCount);
    checkOutput({tag, " BestJob"}, bj, e.bestJob);
    checkOutput({tag, " Busy low at Valid"}, longint'(busy), 0);
  endtask

  // Monitors: pop and compare on each rising edge of Valid
  logic prevValidA = 1'b0;
  logic prevValidB = 1'b0;
  logic prevValidC = 1'b0;
  logic prevValidD = 1'b0;
  exp_t popA, popB, popC, popD;

  always @(negedge CLK) begin
    if (validA && !prevValidA) begin
      checkOutput("A scoreboard entry present", longint'(qA.size() > 0), 1);
      if (qA.size() > 0) begin
        popA = qA.pop_front();
        compareResult("A", popA, minCostA, matchCountA, bestJobA, busyA);
      end
    end
    prevValidA = validA;
  end

  always @(negedge CLK) begin
    if (validB && !prevValidB) begin
      checkOutput("B scoreboard entry present", longint'(qB.size() > 0), 1);
      if (qB.size() > 0) begin
        popB = qB.pop_front();
        compareResult("B", popB, minCostB, matchCountB, bestJobB, busyB);
      end
    end
    prevValidB = validB;
  end

  always @(negedge CLK) begin
    if (validC && !prevValidC) begin
      checkOutput("C scoreboard entry present", longint'(qC.size() > 0), 1);
      if (qC.size() > 0) begin
        popC = qC.pop_front();
        compareResult("C", popC, minCostC, matchCountC, bestJobC, busyC);
      end
    end
    prevValidC = validC;
  end

  always @(negedge CLK) begin
    if (validD && !prevValidD) begin
      checkOutput("D scoreboard entry present", longint'(qD.size() > 0), 1);
      if (qD.size() > 0) begin
        popD = qD.pop_front();
        compareResult("D", popD, minCostD, matchCountD, bestJobD, busyD);
      end
    end
    prevValidD = validD;
  end

  function automatic longint packIdentity(input int n, input int iw);
    longint r;
    r = 0;
    for (int i = 0; i < n; i++) begin
      r = r | (longint'(i) << (i * iw));
    end
    return r;
  endfunction

  // Reference model: brute force over every worker->job map counted in base
  // NA with worker 0 most significant, so ascending codes are lexicographic;
  // maps that reuse a job are skipped.
  function automatic exp_t refModel(input bit maxMode);
    exp_t r;
    bit   have;
    int   digits [NA];
    int   limit;
    r     = '{0, 0, 0};
    have  = 1'b0;
    limit = NA ** NA;
    for (int code = 0; code < limit; code++) begin
      int rem;
      int mask;
      int total;
      bit distinct;
      rem      = code;
      mask     = 0;
      total    = 0;
      distinct = 1'b1;
      for (int w = NA - 1; w >= 0; w--) begin
        digits[w] = rem % NA;
        rem       = rem / NA;
      end
      for (int w = 0; w < NA; w++) begin
        if (((mask >> digits[w]) & 1) != 0) distinct = 1'b0;
        mask  = mask | (1 << digits[w]);
        total = total + int'(costTab[w][digits[w]]);
      end
      if (distinct) begin
        if (!have || (maxMode ? (total > r.minCost) : (total < r.minCost))) begin
          have         = 1'b1;
          r.minCost    = total;
          r.matchCount = 1;
          r.bestJob    = 0;
          for (int w = 0; w < NA; w++) begin
            r.bestJob = r.bestJob | (longint'(digits[w]) << (w * IWA));
          end
        end else if (total == r.minCost) begin
          r.matchCount = r.matchCount + 1;
        end
      end
    end
    return r;
  endfunction

  task automatic randomTable();
    for (int w = 0; w < NA; w++) begin
      for (int j = 0; j < NA; j++) begin
        costTab[w][j] = CWT'($urandom_range(127, 0));
      end
    end
  endtask

  task automatic pulseStart();
    @(negedge CLK) startAB = 1'b1;
    @(negedge CLK) startAB = 1'b0;
  endtask

  task automatic waitAB(output int cycA, output int cycB);
    cycA = -1;
    cycB = -1;
    for (int n = 1; n <= 5000 && (cycA < 0 || cycB < 0); n++) begin
      @(negedge CLK);
      if (cycA < 0 && validA) cycA = n;
      if (cycB < 0 && validB) cycB = n;
    end
    if (cycA < 0 || cycB < 0) checkOutput("AB run finished in budget", 0, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " W"}, wA, 0);
    checkOutput({tag, " J"}, jA, 0);
    checkOutput({tag, " MinCost"}, minCostA, 0);
    checkOutput({tag, " MatchCount"}, matchCountA, 0);
    checkOutput({tag, " BestJob"}, bestJobA, 0);
    checkOutput({tag, " Busy"}, busyA, 0);
    checkOutput({tag, " Valid"}, validA, 0);
  endtask

  // One scoreboarded run on A and B; Mode is scrambled after acceptance to
  // show it is only sampled with Start
  task automatic applyStimulus(input bit mode, input exp_t e);
    int cycA;
    int cycB;
    qA.push_back(e);
    qB.push_back(e);
    modeAB = mode;
    pulseStart();
    checkOutput("A Valid cleared after Start", validA, 0);
    checkOutput("A Busy after Start", busyA, 1);
    modeAB = 1'($urandom);
    waitAB(cycA, cycB);
    checkOutput("A pruned run not slower than B", longint'(cycA <= cycB), 1);
  endtask

  initial begin
    exp_t e;
    bit   m;
    startAB = 1'b0;
    startCD = 1'b0;
    modeAB  = 1'b0;
    RST     = 1'b0;
    for (int w = 0; w < NA; w++) for (int j = 0; j < NA; j++) costTab[w][j] = '0;
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    checkResetState("reset");
    RST = 1'b0;
    @(negedge CLK);

    // Directed: N=3 w*j minimise, and N=6 all-equal costs (ties never pruned)
    e = '{1, 1, 6};
    qC.push_back(e);
    e = '{30, 720, packIdentity(ND, IWD)};
    qD.push_back(e);
    @(negedge CLK) startCD = 1'b1;
    @(negedge CLK) startCD = 1'b0;
    for (int n = 0; n < 20000 && !(validC && validD); n++) @(negedge CLK);
    if (!(validC && validD)) checkOutput("CD run finished in budget", 0, 1);

    // Directed: N=4 maximise with a heavy diagonal
    for (int w = 0; w < NA; w++) for (int j = 0; j < NA; j++) costTab[w][j] = (w == j) ? CWT'(9) : CWT'(1);
    e = '{36, 1, packIdentity(NA, IWA)};
    applyStimulus(1'b1, e);

    // Random tables and modes against the model
    for (int r = 0; r < 10; r++) begin
      randomTable();
      m = 1'($urandom);
      applyStimulus(m, refModel(m));
    end

    // Start while Busy is ignored; a Start after Valid reproduces the result
    randomTable();
    m = 1'($urandom);
    e = refModel(m);
    qA.push_back(e);
    qB.push_back(e);
    modeAB = m;
    pulseStart();
    repeat (5) @(negedge CLK);
    modeAB = ~m;
    pulseStart();
    checkOutput("A Busy unaffected by Start while busy", busyA, 1);
    begin
      int ca;
      int cb;
      waitAB(ca, cb);
    end
    applyStimulus(m, e);

    // Reset in the middle of SUM, then a clean rerun
    randomTable();
    m = 1'($urandom);
    modeAB = m;
    pulseStart();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #2;
    checkResetState("mid-run reset");
    @(negedge CLK) RST = 1'b0;
    repeat (10) @(negedge CLK);
    checkResetState("idle after reset");
    applyStimulus(m, refModel(m));

    repeat (3) @(negedge CLK);
    checkOutput("A queue drained", qA.size(), 0);
    checkOutput("B queue drained", qB.size(), 0);
    checkOutput("C queue drained", qC.size(), 0);
    checkOutput("D queue drained", qD.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
